// File: rtl/inst_fetch.sv
// Instruction fetch stage ahead of a registered-read instruction memory: owns the PC,
// tracks the one-cycle read latency and feeds decode over valid/ready. Optional perf counters: INST_FETCH_PERF_EN.
module inst_fetch #(
  parameter int ADDR_W = 3,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_inst,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              br_en,
  input  logic [ADDR_W-1:0] br_target
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetch,
  output logic [15:0]       perf_stall
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic              fv_q, fv_d;
  logic              issue;

  assign out_valid = fv_q;
  assign out_pc    = fpc_q;
  assign out_inst  = mem_inst;

  // While decode stalls, re-read the held address so the registered memory output stays put.
  always_comb begin
    mem_addr = pc_q;
    if (br_en)
      mem_addr = br_target;
    else if (state_q == RUN && fv_q && !out_ready)
      mem_addr = fpc_q;
  end

  assign issue = en && (state_q == IDLE || br_en || !fv_q || out_ready);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fpc_d   = fpc_q;
    fv_d    = fv_q;
    if (issue) begin
      pc_d    = mem_addr + ADDR_W'(1);
      fpc_d   = mem_addr;
      fv_d    = 1'b1;
      state_d = RUN;
    end else if (br_en) begin
      pc_d    = br_target;
      fv_d    = 1'b0;
      state_d = IDLE;
    end else if (state_q == RUN && !(fv_q && !out_ready)) begin
      fv_d    = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      fpc_q   <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fpc_q   <= fpc_d;
      fv_q    <= fv_d;
    end
  end

`ifdef INST_FETCH_PERF_EN
  logic [15:0] fetchCnt_q, stallCnt_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetchCnt_q <= '0;
      stallCnt_q <= '0;
    end else begin
      if (issue && fetchCnt_q != 16'hFFFF)
        fetchCnt_q <= fetchCnt_q + 16'd1;
      if (fv_q && !out_ready && stallCnt_q != 16'hFFFF)
        stallCnt_q <= stallCnt_q + 16'd1;
    end
  end

  assign perf_fetch = fetchCnt_q;
  assign perf_stall = stallCnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch with a registered-read memory model whose word at A is A*65.
// Perf counter checks are compiled in when INST_FETCH_PERF_EN is defined.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst, en, outReady, brEn;
  logic [2:0]  brTarget, memAddr, outPc;
  logic [15:0] memInst, outInst;
  logic        outValid;
`ifdef INST_FETCH_PERF_EN
  logic [15:0] perfFetch, perfStall;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       en;
    logic       ready;
    logic       br;
    logic [2:0] tgt;
    logic       expValid;
    logic [2:0] expPc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  inst_fetch #(.ADDR_W(3), .INST_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mem_addr  (memAddr),
    .mem_inst  (memInst),
    .out_inst  (outInst),
    .out_pc    (outPc),
    .out_valid (outValid),
    .out_ready (outReady),
    .br_en     (brEn),
    .br_target (brTarget)
`ifdef INST_FETCH_PERF_EN
    ,
    .perf_fetch(perfFetch),
    .perf_stall(perfStall)
`endif
  );

  function automatic logic [15:0] memWord(input logic [2:0] a);
    return 16'(a) * 16'd65;
  endfunction

  always @(posedge clk) memInst <= memWord(memAddr);

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic r, input logic b, input logic [2:0] t);
    en       = e;
    outReady = r;
    brEn     = b;
    brTarget = t;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic e, input logic r, input logic b, input logic [2:0] t,
                        input logic v, input logic [2:0] p);
    vec_t x;
    x.en = e; x.ready = r; x.br = b; x.tgt = t; x.expValid = v; x.expPc = p;
    vecs.push_back(x);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; outReady = 1'b0; brEn = 1'b0; brTarget = '0;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("reset_valid", 16'(outValid), 16'd0);
    checkOutput("reset_pc", 16'(outPc), 16'd0);
    checkOutput("reset_addr", 16'(memAddr), 16'd0);
    rst = 1'b0;

    // Streaming, wrap, stall at 3, en drop at 5, resume, branches.
    for (int i = 0; i < 10; i++) addVec(1, 1, 0, 0, 1, 3'(i));
    addVec(1, 1, 0, 0, 1, 2);
    addVec(1, 1, 0, 0, 1, 3);
    for (int i = 0; i < 3; i++) addVec(1, 0, 0, 0, 1, 3);
    addVec(1, 1, 0, 0, 1, 4);
    addVec(1, 1, 0, 0, 1, 5);
    addVec(0, 0, 0, 0, 1, 5);
    addVec(0, 0, 0, 0, 1, 5);
    addVec(0, 1, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 0, 0);
    addVec(1, 1, 0, 0, 1, 6);
    addVec(1, 1, 0, 0, 1, 7);
    addVec(1, 1, 0, 0, 1, 0);
    addVec(1, 1, 0, 0, 1, 1);
    addVec(1, 1, 0, 0, 1, 2);
    addVec(1, 1, 1, 6, 1, 6);
    addVec(1, 1, 0, 0, 1, 7);
    addVec(1, 1, 0, 0, 1, 0);
    addVec(1, 0, 1, 3, 1, 3);
    addVec(1, 1, 0, 0, 1, 4);
    addVec(0, 1, 1, 2, 0, 0);
    addVec(1, 1, 0, 0, 1, 2);
    addVec(1, 1, 1, 7, 1, 7);
    addVec(1, 1, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].ready, vecs[i].br, vecs[i].tgt);
      checkOutput($sformatf("v%0d_valid", i), 16'(outValid), 16'(vecs[i].expValid));
      if (vecs[i].expValid) begin
        checkOutput($sformatf("v%0d_pc", i), 16'(outPc), 16'(vecs[i].expPc));
        checkOutput($sformatf("v%0d_inst", i), outInst, memWord(vecs[i].expPc));
      end
    end

`ifdef INST_FETCH_PERF_EN
    checkOutput("perf_fetch_count", perfFetch, 16'd27);
    checkOutput("perf_stall_count", perfStall, 16'd6);
`endif

    // Reset mid-stream must beat a simultaneous branch and enable.
    rst = 1'b1;
    applyStimulus(1, 1, 1, 5);
    checkOutput("rst_valid", 16'(outValid), 16'd0);
    brEn = 1'b0;
    #1;
    checkOutput("rst_addr", 16'(memAddr), 16'd0);
    checkOutput("rst_pc", 16'(outPc), 16'd0);
`ifdef INST_FETCH_PERF_EN
    checkOutput("rst_perf_fetch", perfFetch, 16'd0);
    checkOutput("rst_perf_stall", perfStall, 16'd0);
`endif
    rst = 1'b0;
    applyStimulus(1, 1, 0, 0);
    checkOutput("post_rst_valid", 16'(outValid), 16'd1);
    checkOutput("post_rst_pc", 16'(outPc), 16'd0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("post_rst_pc1", 16'(outPc), 16'd1);
    checkOutput("post_rst_inst1", outInst, 16'h0041);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage placed directly upstream of `inst_memory`. It owns the program counter, drives the memory's 3-bit address and tracks the memory's one-cycle registered read latency. It presents each fetched instruction and its address to the decode stage over a valid/ready handshake. It also supports stall, redirect (branch) and run/idle control.

## Interface
- `ADDR_W`, 3: program counter and memory address width; address space is 2^ADDR_W words.
- `INST_W`, 16: instruction width, equal to the `inst_memory` output width.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: run enable; 0 stops issuing new fetches.
- `mem_addr` output ADDR_W: address to `inst_memory` (combinational from state and inputs).
- `mem_inst` input INST_W: `inst_memory` registered output; valid one cycle after the address.
- `out_inst` output INST_W: instruction to decode; equals `mem_inst`.
- `out_pc` output ADDR_W: address of `out_inst`.
- `out_valid` output 1: `out_inst`/`out_pc` carry a live instruction.
- `out_ready` input 1: decode accepts this cycle; a transfer happens when `out_valid & out_ready`.
- `br_en` input 1: redirect request; squashes the current output.
- `br_target` input ADDR_W: redirect address.

## Operation
- State:
  - `pc`: next address to issue.
  - `f_pc`: address whose data is in `mem_inst`.
  - `f_v`: `mem_inst` is live.
  - FSM: `IDLE` or `RUN`.
- `out_valid = f_v`. `out_pc = f_pc`. `out_inst = mem_inst`.
- `mem_addr` selection, first match wins:
  1. `br_en` (either state): `br_target`.
  2. `RUN` and `out_valid & ~out_ready`: `f_pc`. This re-reads the held instruction so `mem_inst` stays stable.
  3. Otherwise: `pc`.
- An issue occurs when either:
  - `RUN`, `en=1`, and (`br_en`, or `~f_v`, or `out_ready`), or
  - `IDLE` and `en=1`.
- On issue of address A: `pc <= A+1` (mod 2^ADDR_W), `f_pc <= A`, `f_v <= 1`.
- `br_en=1` with `en=0`:
  - `pc <= br_target`, `f_v <= 0`, state goes to `IDLE`.
  - The current output is discarded even if `out_ready=1`.
- `br_en=1` with `en=1`: the current output is discarded and the target is issued. Decode must not treat a same-cycle `out_valid & out_ready` as a transfer.
- No issue in `RUN` (`en=0`, `br_en=0`):
  - If `f_v & ~out_ready`: hold all state.
  - Otherwise: `f_v <= 0` and state goes to `IDLE`.
- FSM transitions:
  - `IDLE`→`RUN` on `en=1`.
  - `RUN`→`IDLE` on `en=0` once no un-accepted output remains, or on a branch with `en=0`.
- Wrap-around: `pc` wraps from 2^ADDR_W−1 to 0 with no flag; `br_target+1` wraps the same way.

## Timing
- Reset values:
  - `pc=0`, `f_pc=0`, `f_v=0`, state `IDLE`.
  - Outputs: `out_valid=0`, `out_pc=0`, `mem_addr=0`.
  - Perf counters are 0.
- Fetch latency: address issued in cycle t gives `out_valid=1` with that instruction in cycle t+1.
- Throughput: 1 instruction/cycle while `en=1` and `out_ready=1`.
- Branch penalty: 1 cycle. The target appears on `out_inst` the cycle after `br_en`.
- Stall: `out_inst`/`out_pc` stay stable for every cycle `out_valid & ~out_ready` holds, with no lost or duplicated transfer.
- `rst` overrides everything, including `br_en` and `en`, in the same cycle.
- `rst` asserted mid-stream drops any pending instruction; `out_valid=0` in the next cycle.

## Configuration
- `INST_FETCH_PERF_EN` defined: adds two outputs.
  - `perf_fetch` (16-bit): increments on each issue.
  - `perf_stall` (16-bit): increments each cycle `out_valid & ~out_ready`.
  - Both saturate at 0xFFFF and clear on `rst`.
- `INST_FETCH_PERF_EN` undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset, then `en=1`, `out_ready=1` for 10 cycles. Required response:
  - `out_valid` goes high 1 cycle after the first issue.
  - `out_pc` sequence is 0,1,…,7,0,1.
  - `out_inst` matches memory contents, e.g. pc 1 → 16'h0041.
- Stream running, hold `out_ready=0` for 3 cycles at `out_pc=3`. Required response:
  - `out_pc=3` and `out_inst=16'h00C3` stable for all 3 cycles.
  - After release, the next accepted `out_pc` is 4.
- `br_en=1`, `br_target=6` while `out_pc=2` is valid and ready. Required response:
  - pc 2 is squashed.
  - Next cycle `out_pc=6`, then 7, then 0.
- `br_en` and `out_ready=0` in the same cycle. Required response: the branch wins and the next cycle shows `out_pc=target`.
- `en` dropped while `out_pc=5` is stalled. Required response:
  - pc 5 stays presented until accepted.
  - Then `out_valid=0`, state `IDLE`.
  - When `en` is re-raised, the stream resumes at `out_pc=6`.
- `rst` asserted mid-stream. Required response:
  - Next cycle `out_valid=0`, `mem_addr=0`.
  - With `INST_FETCH_PERF_EN` defined, `perf_fetch=0` and `perf_stall=0`.
